// File: rtl/inst_decode_stage.sv
// Registered decode stage: classifies fetched instructions, extracts register/funct fields,
// and buffers them in a two-entry skid buffer with a registered in_ready.
module inst_decode_stage #(
    parameter int          XLEN      = 32,
    parameter logic [3:0]  ILLEGAL_T = 4'hF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      t,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] pc,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [2:0]      funct3,
    output logic            funct7b5,
    output logic            illegal
);

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic [3:0]      t;
        logic            illegal;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic            funct7b5;
    } entry_t;

    entry_t in_entry, out_q, out_d, skid_q, skid_d;
    logic   out_valid_q, out_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   in_ready_q;
    logic   accept, out_free;

    // Decode happens once, on the way in; the stored entry carries the result.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        in_entry          = '0;
        in_entry.inst     = in_inst;
        in_entry.pc       = in_pc;
        in_entry.rd       = in_inst[11:7];
        in_entry.rs1      = in_inst[19:15];
        in_entry.rs2      = in_inst[24:20];
        in_entry.funct3   = in_inst[14:12];
        in_entry.funct7b5 = in_inst[30];
        in_entry.t        = ILLEGAL_T;
        in_entry.illegal  = 1'b1;
        case (in_inst[6:0])
            7'b0000011: begin in_entry.t = 4'd0; in_entry.illegal = 1'b0; end
            7'b0010011: begin in_entry.t = 4'd1; in_entry.illegal = 1'b0; end
            7'b0100011: begin in_entry.t = 4'd2; in_entry.illegal = 1'b0; end
            7'b0110011: begin in_entry.t = 4'd3; in_entry.illegal = 1'b0; end
            7'b0110111: begin in_entry.t = 4'd4; in_entry.illegal = 1'b0; end
            7'b0010111: begin in_entry.t = 4'd5; in_entry.illegal = 1'b0; end
            7'b1100011: begin in_entry.t = 4'd6; in_entry.illegal = 1'b0; end
            7'b1100111: begin in_entry.t = 4'd7; in_entry.illegal = 1'b0; end
            7'b1101111: begin in_entry.t = 4'd8; in_entry.illegal = 1'b0; end
            default: ;
        endcase
    end

    assign accept   = in_valid & in_ready_q;
    assign out_free = !out_valid_q || out_ready;

    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                // Skid entry is older than anything arriving now, so it moves up first.
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = accept;
                if (accept) skid_d = in_entry;
            end else begin
                out_valid_d = accept;
                if (accept) out_d = in_entry;
            end
        end else if (accept) begin
            skid_d       = in_entry;
            skid_valid_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
            out_q        <= '0;
            out_q.t      <= ILLEGAL_T;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= !skid_valid_d;
            out_q        <= out_d;
        end
    end

    // NOTE: skid payload is qualified by skid_valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        skid_q <= skid_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign t         = out_q.t;
    assign inst      = out_q.inst;
    assign pc        = out_q.pc;
    assign rd        = out_q.rd;
    assign rs1       = out_q.rs1;
    assign rs2       = out_q.rs2;
    assign funct3    = out_q.funct3;
    assign funct7b5  = out_q.funct7b5;
    assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_inst_decode_stage.sv
// Self-checking bench for inst_decode_stage: directed scenarios plus random traffic,
// compared each cycle against a queue model of an in-order two-entry buffer.
module tb_inst_decode_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_inst, in_pc;
    logic        in_ready, out_valid, funct7b5, illegal;
    logic [3:0]  t;
    logic [31:0] inst, pc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;

    always #5 clk = ~clk;

    inst_decode_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .t(t), .inst(inst), .pc(pc), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7b5(funct7b5), .illegal(illegal)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } item_t;

    localparam logic [6:0] OPCODES [9] = '{7'b0000011, 7'b0010011, 7'b0100011,
                                           7'b0110011, 7'b0110111, 7'b0010111,
                                           7'b1100011, 7'b1100111, 7'b1101111};

    int          errors = 0;
    int          checks = 0;
    item_t       model_q[$];
    bit          ready_blocked = 1'b1;
    bit          fresh = 1'b1;
    logic [31:0] pc_ctr = 32'h1000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Type code is the position of the opcode in the type list; unknown opcodes give 15.
    function automatic logic [3:0] type_of(input logic [31:0] i);
        for (int k = 0; k < 9; k++)
            if (i[6:0] == OPCODES[k]) return 4'(k);
        return 4'hF;
    endfunction

    function automatic bit exp_ready();
        return !ready_blocked && (model_q.size() < 2);
    endfunction

    task automatic cycle();
        bit    acc, drn;
        item_t it;
        acc     = in_valid && exp_ready();
        drn     = (model_q.size() > 0) && out_ready;
        it.inst = in_inst;
        it.pc   = in_pc;
        @(posedge clk);
        if (rst) begin
            model_q.delete();
            ready_blocked = 1'b1;
            fresh         = 1'b1;
        end else if (flush) begin
            model_q.delete();
            ready_blocked = 1'b0;
        end else begin
            if (drn) void'(model_q.pop_front());
            if (acc) begin
                model_q.push_back(it);
                fresh = 1'b0;
            end
            ready_blocked = 1'b0;
        end
        #1;
        check("in_ready", 32'(in_ready), 32'(exp_ready()));
        check("out_valid", 32'(out_valid), 32'(model_q.size() > 0));
        if (model_q.size() > 0) begin
            it = model_q[0];
            check("inst", inst, it.inst);
            check("pc", pc, it.pc);
            check("t", 32'(t), 32'(type_of(it.inst)));
            check("illegal", 32'(illegal), 32'(type_of(it.inst) == 4'hF));
            check("rd", 32'(rd), 32'((it.inst >> 7) & 32'h1F));
            check("rs1", 32'(rs1), 32'((it.inst >> 15) & 32'h1F));
            check("rs2", 32'(rs2), 32'((it.inst >> 20) & 32'h1F));
            check("funct3", 32'(funct3), 32'((it.inst >> 12) & 32'h7));
            check("funct7b5", 32'(funct7b5), 32'((it.inst >> 30) & 32'h1));
        end else if (fresh) begin
            check("reset_t", 32'(t), 32'hF);
            check("reset_illegal", 32'(illegal), 32'h0);
            check("reset_inst", inst, 32'h0);
            check("reset_pc", pc, 32'h0);
            check("reset_rd", 32'(rd), 32'h0);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] i, input logic r,
                         input logic f = 1'b0, input logic rs = 1'b0);
        in_valid  = v;
        in_inst   = i;
        in_pc     = pc_ctr;
        pc_ctr    = pc_ctr + 32'd4;
        out_ready = r;
        flush     = f;
        rst       = rs;
        cycle();
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        r = $urandom();
        if ($urandom_range(0, 9) < 9) r[6:0] = OPCODES[$urandom_range(0, 8)];
        return r;
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_pc = '0;
        drive(0, 0, 1, 0, 1);
        drive(0, 0, 1, 0, 1);

        // addi x1,x0,5 right after reset; first cycle out of reset in_ready is still low
        drive(1, 32'h00500093, 1);
        drive(1, 32'h00500093, 1);
        drive(0, 0, 1);

        // lw sw add lui auipc beq jalr jal back to back
        for (int k = 0; k < 9; k++) begin
            logic [31:0] w;
            if (k == 1) continue;
            w = $urandom();
            w[6:0] = OPCODES[k];
            drive(1, w, 1);
        end
        drive(0, 0, 1);
        drive(0, 0, 1);

        // stall with two entries, then release
        drive(1, 32'h00A30313, 0);
        drive(1, 32'h40B50533, 0);
        drive(0, 0, 0);
        drive(0, 0, 0);
        drive(0, 0, 1);
        drive(0, 0, 1);
        drive(0, 0, 1);

        // bad opcodes
        drive(1, 32'h0000007F, 1);
        drive(1, 32'h00000010, 1);
        drive(0, 0, 1);

        // flush with both entries full and a same-cycle input
        drive(1, 32'h00112023, 0);
        drive(1, 32'h0041A283, 0);
        drive(1, 32'h123450B7, 0, 1);
        drive(0, 0, 1);
        drive(0, 0, 1);

        // reset with both entries full
        drive(1, 32'h00208063, 0);
        drive(1, 32'h000080E7, 0);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 1);
        drive(0, 0, 1);

        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 9) < 7, rand_inst(), $urandom_range(0, 9) < 6,
                  $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
